// File: rtl/hazard_pkg.sv
// ---------------------------------------------------------------------------
// hazard_pkg
// Shared definitions for the hazard scoreboard: register tag width,
// operand-forwarding mux selects, multi-cycle timer state encoding and the
// tag of integer register x0 (the only register that never carries a hazard).
// Ports: none (package).
// ---------------------------------------------------------------------------
package hazard_pkg;

  // Architectural register index width; the extra tag MSB selects the FP file.
  localparam int REG_AW_DEF = 5;
  localparam int TAG_W      = REG_AW_DEF + 1;

  // Execute-stage operand mux selects.
  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  // Multi-cycle operation timer states.
  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } mdu_state_e;

  // Integer x0 is hard-wired zero; FP f0 ({1'b1, 0}) is a real register.
  localparam logic [TAG_W-1:0] INT_X0_TAG = '0;

endpackage

// File: rtl/hazard_mdu_timer.sv
// ---------------------------------------------------------------------------
// hazard_mdu_timer
// Times a multi-cycle (M-extension / FPU) operation held in Execute so that
// it occupies the stage for exactly MDU_LAT non-frozen cycles.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   i_start       Execute holds a multi-cycle op
//   i_freeze      data memory wait state; timer holds its state
//   o_mduStall    Execute must be held this cycle (combinational)
//   o_mduBusy     timer is in BUSY (registered)
// ---------------------------------------------------------------------------
module hazard_mdu_timer
  import hazard_pkg::*;
#(
  parameter int MDU_LAT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_start,
  input  logic i_freeze,
  output logic o_mduStall,
  output logic o_mduBusy
);

  localparam bit MULTI = (MDU_LAT > 1);
  localparam int CNT_W = (MDU_LAT > 1) ? $clog2(MDU_LAT) : 1;
  // The IDLE cycle that accepts the op already counts as the first cycle,
  // and the final BUSY cycle with cnt==0 releases, hence the -2.
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((MDU_LAT > 1) ? (MDU_LAT - 2) : 0);

  mdu_state_e       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_mduBusy;

  // Single FSM block: state, countdown and the registered busy flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_mduBusy <= 1'b0;
    end else if (!i_freeze) begin
      case (r_state)
        S_IDLE: begin
          if (i_start && MULTI) begin
            r_state   <= S_BUSY;
            r_cnt     <= CNT_LOAD;
            r_mduBusy <= 1'b1;
          end
        end
        S_BUSY: begin
          if (r_cnt == '0) begin
            r_state   <= S_IDLE;
            r_mduBusy <= 1'b0;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_mduBusy <= 1'b0;
        end
      endcase
    end
  end

  // Stall must assert in the very cycle the op enters Execute, so it is
  // decoded from the current state rather than registered.
  assign o_mduStall = (r_state == S_IDLE) ? (i_start && MULTI) : (r_cnt != '0);
  assign o_mduBusy  = r_mduBusy;

endmodule

// File: rtl/hazard_scoreboard.sv
// ---------------------------------------------------------------------------
// hazard_scoreboard
// Hazard controller for the 5-stage pipeline: operand forwarding selects,
// load-use detection, multi-cycle op timing and stall/flush sequencing for
// the F/D/E/M/W pipeline registers. Integer and FP registers share one tag
// space (tag MSB = FP).
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   D_Rs, D_SrcValid                Decode source tags / source-used flags
//   E_Rs                            Execute source tags
//   E_Rd, M_Rd, W_Rd, *_RegWrite    destination tags and write enables
//   E_IsLoad, E_MulDiv, E_PCSrc     Execute holds load / multi-cycle op / taken branch
//   M_MemStall                      data memory not ready
//   Forward_E                       per-source mux select (00 RF, 01 W, 10 M)
//   F/D/E/M_Stall, D/E/M/W_Flush    pipeline register controls
//   mdu_busy                        multi-cycle timer in BUSY
// ---------------------------------------------------------------------------
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int REG_AW  = 5,
  parameter int NSRC    = 3,
  parameter int MDU_LAT = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NSRC*(REG_AW+1)-1:0]   D_Rs,
  input  logic [NSRC-1:0]              D_SrcValid,
  input  logic [NSRC*(REG_AW+1)-1:0]   E_Rs,
  input  logic [REG_AW:0]              E_Rd,
  input  logic [REG_AW:0]              M_Rd,
  input  logic [REG_AW:0]              W_Rd,
  input  logic                         E_RegWrite,
  input  logic                         M_RegWrite,
  input  logic                         W_RegWrite,
  input  logic                         E_IsLoad,
  input  logic                         E_MulDiv,
  input  logic                         E_PCSrc,
  input  logic                         M_MemStall,
  output logic [2*NSRC-1:0]            Forward_E,
  output logic                         F_Stall,
  output logic                         D_Stall,
  output logic                         E_Stall,
  output logic                         M_Stall,
  output logic                         D_Flush,
  output logic                         E_Flush,
  output logic                         M_Flush,
  output logic                         W_Flush,
  output logic                         mdu_busy
);

  localparam int TW = REG_AW + 1;
  localparam logic [TW-1:0] X0_TAG = TW'(INT_X0_TAG);

  logic [NSRC-1:0]   w_luHit;
  logic [2*NSRC-1:0] w_fwd;
  logic              w_loadUse;
  logic              w_mduStall;
  logic              w_mduBusy;

  hazard_mdu_timer #(
    .MDU_LAT (MDU_LAT)
  ) u_mdu_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_start    (E_MulDiv),
    .i_freeze   (M_MemStall),
    .o_mduStall (w_mduStall),
    .o_mduBusy  (w_mduBusy)
  );

  // Per-source comparators: forwarding for Execute, load-use match for Decode.
  for (genvar gi = 0; gi < NSRC; gi++) begin : g_src
    logic [TW-1:0] w_eSrc;
    logic [TW-1:0] w_dSrc;
    logic          w_mHit;
    logic          w_wHit;

    assign w_eSrc = E_Rs[gi*TW +: TW];
    assign w_dSrc = D_Rs[gi*TW +: TW];
    assign w_mHit = M_RegWrite && (M_Rd != X0_TAG) && (w_eSrc == M_Rd);
    assign w_wHit = W_RegWrite && (W_Rd != X0_TAG) && (w_eSrc == W_Rd);
    // M holds the younger result, so it wins over W.
    assign w_fwd[gi*2 +: 2] = w_mHit ? FWD_M : (w_wHit ? FWD_W : FWD_RF);
    assign w_luHit[gi]      = D_SrcValid[gi] && (w_dSrc == E_Rd);
  end

  assign w_loadUse = E_IsLoad && E_RegWrite && (E_Rd != X0_TAG) && (|w_luHit);

  // Priority: memory wait > multi-cycle op > taken branch > load-use.
  // During reset every stage is loaded with a bubble.
  always_comb begin
    Forward_E = w_fwd;
    F_Stall   = 1'b0;
    D_Stall   = 1'b0;
    E_Stall   = 1'b0;
    M_Stall   = 1'b0;
    D_Flush   = 1'b0;
    E_Flush   = 1'b0;
    M_Flush   = 1'b0;
    W_Flush   = 1'b0;
    if (!rst_n) begin
      Forward_E = '0;
      D_Flush   = 1'b1;
      E_Flush   = 1'b1;
      M_Flush   = 1'b1;
      W_Flush   = 1'b1;
    end else if (M_MemStall) begin
      // A taken branch waits here; it is still in Execute when the stall drops.
      F_Stall = 1'b1;
      D_Stall = 1'b1;
      E_Stall = 1'b1;
      M_Stall = 1'b1;
      W_Flush = 1'b1;
    end else if (w_mduStall) begin
      F_Stall = 1'b1;
      D_Stall = 1'b1;
      E_Stall = 1'b1;
      M_Flush = 1'b1;
    end else if (E_PCSrc) begin
      D_Flush = 1'b1;
      E_Flush = 1'b1;
    end else if (w_loadUse) begin
      F_Stall = 1'b1;
      D_Stall = 1'b1;
      E_Flush = 1'b1;
    end
  end

  assign mdu_busy = w_mduBusy;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// ---------------------------------------------------------------------------
// tb_hazard_scoreboard
// Self-checking bench for hazard_scoreboard: a behavioural model (remaining
// occupancy of the multi-cycle op plus the priority rules) is compared
// against the DUT on every falling edge, and directed vectors carry
// hand-computed expected values.
// ---------------------------------------------------------------------------
module tb_hazard_scoreboard;
  import hazard_pkg::*;

  localparam int REG_AW  = 5;
  localparam int NSRC    = 3;
  localparam int MDU_LAT = 4;
  localparam int TW      = REG_AW + 1;

  typedef struct packed {
    logic [NSRC*TW-1:0] dRs;
    logic [NSRC-1:0]    dSrcValid;
    logic [NSRC*TW-1:0] eRs;
    logic [TW-1:0]      eRd;
    logic [TW-1:0]      mRd;
    logic [TW-1:0]      wRd;
    logic               eRegWrite;
    logic               mRegWrite;
    logic               wRegWrite;
    logic               eIsLoad;
    logic               eMulDiv;
    logic               ePCSrc;
    logic               memStall;
  } stim_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NSRC*TW-1:0] D_Rs = '0;
  logic [NSRC-1:0]    D_SrcValid = '0;
  logic [NSRC*TW-1:0] E_Rs = '0;
  logic [TW-1:0]      E_Rd = '0;
  logic [TW-1:0]      M_Rd = '0;
  logic [TW-1:0]      W_Rd = '0;
  logic E_RegWrite = 1'b0, M_RegWrite = 1'b0, W_RegWrite = 1'b0;
  logic E_IsLoad = 1'b0, E_MulDiv = 1'b0, E_PCSrc = 1'b0, M_MemStall = 1'b0;
  logic [2*NSRC-1:0] Forward_E;
  logic F_Stall, D_Stall, E_Stall, M_Stall;
  logic D_Flush, E_Flush, M_Flush, W_Flush;
  logic mdu_busy;

  int checks = 0;
  int errors = 0;
  int mRemain = 0;

  stim_t s;

  hazard_scoreboard #(
    .REG_AW  (REG_AW),
    .NSRC    (NSRC),
    .MDU_LAT (MDU_LAT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .D_Rs       (D_Rs),
    .D_SrcValid (D_SrcValid),
    .E_Rs       (E_Rs),
    .E_Rd       (E_Rd),
    .M_Rd       (M_Rd),
    .W_Rd       (W_Rd),
    .E_RegWrite (E_RegWrite),
    .M_RegWrite (M_RegWrite),
    .W_RegWrite (W_RegWrite),
    .E_IsLoad   (E_IsLoad),
    .E_MulDiv   (E_MulDiv),
    .E_PCSrc    (E_PCSrc),
    .M_MemStall (M_MemStall),
    .Forward_E  (Forward_E),
    .F_Stall    (F_Stall),
    .D_Stall    (D_Stall),
    .E_Stall    (E_Stall),
    .M_Stall    (M_Stall),
    .D_Flush    (D_Flush),
    .E_Flush    (E_Flush),
    .M_Flush    (M_Flush),
    .W_Flush    (W_Flush),
    .mdu_busy   (mdu_busy)
  );

  always #5 clk = ~clk;

  // Cycles the current multi-cycle op still needs in Execute, counting this one.
  function automatic int effRemain();
    if (mRemain == 0 && E_MulDiv) return MDU_LAT;
    return mRemain;
  endfunction

  // Model state: one Execute cycle is consumed per non-memory-stalled clock.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) mRemain <= 0;
    else if (!M_MemStall) mRemain <= (effRemain() > 0) ? effRemain() - 1 : 0;
  end

  // Compare process: model outputs versus DUT on every falling edge.
  always @(negedge clk) begin
    logic [2*NSRC-1:0] eFwd;
    logic [3:0]        eSt;
    logic [3:0]        eFl;
    logic              eBusy;
    logic              eLu;
    logic [TW-1:0]     src;
    eFwd  = '0;
    eSt   = '0;
    eFl   = '0;
    eLu   = 1'b0;
    eBusy = (mRemain > 0);
    if (!rst_n) begin
      eFl   = 4'b1111;
      eBusy = 1'b0;
    end else begin
      for (int i = 0; i < NSRC; i++) begin
        src = E_Rs[i*TW +: TW];
        if (src != '0 && M_RegWrite && M_Rd == src) eFwd[i*2 +: 2] = 2'b10;
        else if (src != '0 && W_RegWrite && W_Rd == src) eFwd[i*2 +: 2] = 2'b01;
        if (E_IsLoad && E_RegWrite && E_Rd != '0 && D_SrcValid[i] && D_Rs[i*TW +: TW] == E_Rd)
          eLu = 1'b1;
      end
      if (M_MemStall) begin
        eSt = 4'b1111; eFl = 4'b0001;
      end else if (effRemain() > 1) begin
        eSt = 4'b1110; eFl = 4'b0010;
      end else if (E_PCSrc) begin
        eFl = 4'b1100;
      end else if (eLu) begin
        eSt = 4'b1100; eFl = 4'b0100;
      end
    end
    checks++;
    if ({F_Stall, D_Stall, E_Stall, M_Stall} !== eSt || {D_Flush, E_Flush, M_Flush, W_Flush} !== eFl ||
        Forward_E !== eFwd || mdu_busy !== eBusy) begin
      errors++;
      $display("[TB] FAIL model t=%0t actual st=%b fl=%b fwd=%b busy=%b expected st=%b fl=%b fwd=%b busy=%b",
               $time, {F_Stall, D_Stall, E_Stall, M_Stall}, {D_Flush, E_Flush, M_Flush, W_Flush},
               Forward_E, mdu_busy, eSt, eFl, eFwd, eBusy);
    end
  end

  // Taken branch and multi-cycle op never share Execute.
  always @(negedge clk) begin
    if (rst_n) assert (!(E_PCSrc && E_MulDiv)) else $error("[TB] FAIL excl PCSrc and MulDiv both high");
  end

  task automatic applyStimulus(input stim_t v);
    @(posedge clk);
    #1;
    D_Rs       = v.dRs;
    D_SrcValid = v.dSrcValid;
    E_Rs       = v.eRs;
    E_Rd       = v.eRd;
    M_Rd       = v.mRd;
    W_Rd       = v.wRd;
    E_RegWrite = v.eRegWrite;
    M_RegWrite = v.mRegWrite;
    W_RegWrite = v.wRegWrite;
    E_IsLoad   = v.eIsLoad;
    E_MulDiv   = v.eMulDiv;
    E_PCSrc    = v.ePCSrc;
    M_MemStall = v.memStall;
  endtask

  // Hand-computed check; stall order {F,D,E,M}, flush order {D,E,M,W}.
  task automatic checkOutput(input string name, input bit waitEdge, input logic [3:0] expSt,
                             input logic [3:0] expFl, input logic [2*NSRC-1:0] expFwd,
                             input logic expBusy);
    if (waitEdge) begin
      @(negedge clk);
      #1;
    end
    checks++;
    if ({F_Stall, D_Stall, E_Stall, M_Stall} !== expSt || {D_Flush, E_Flush, M_Flush, W_Flush} !== expFl ||
        Forward_E !== expFwd || mdu_busy !== expBusy) begin
      errors++;
      $display("[TB] FAIL %s actual st=%b fl=%b fwd=%b busy=%b expected st=%b fl=%b fwd=%b busy=%b",
               name, {F_Stall, D_Stall, E_Stall, M_Stall}, {D_Flush, E_Flush, M_Flush, W_Flush},
               Forward_E, mdu_busy, expSt, expFl, expFwd, expBusy);
    end
  endtask

  initial begin
    s = '0;
    $display("[TB] start");
    repeat (2) @(posedge clk);
    checkOutput("reset", 1'b1, 4'b0000, 4'b1111, 6'b000000, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Forwarding: M beats W on x5; x0 never forwards; FP f0 forwards.
    s = '0; s.eRs = {6'd0, 6'd0, 6'd5}; s.mRd = 6'd5; s.mRegWrite = 1'b1; s.wRd = 6'd5; s.wRegWrite = 1'b1;
    applyStimulus(s); checkOutput("fwd_x5_M", 1'b1, 4'b0000, 4'b0000, 6'b000010, 1'b0);
    s.mRegWrite = 1'b0;
    applyStimulus(s); checkOutput("fwd_x5_W", 1'b1, 4'b0000, 4'b0000, 6'b000001, 1'b0);
    s = '0; s.mRegWrite = 1'b1; s.wRegWrite = 1'b1;
    applyStimulus(s); checkOutput("fwd_x0", 1'b1, 4'b0000, 4'b0000, 6'b000000, 1'b0);
    s = '0; s.eRs = {6'd0, 6'b100000, 6'd0}; s.mRd = 6'd9; s.mRegWrite = 1'b1;
    s.wRd = 6'b100000; s.wRegWrite = 1'b1;
    applyStimulus(s); checkOutput("fwd_f0_W", 1'b1, 4'b0000, 4'b0000, 6'b000100, 1'b0);
    s.mRd = 6'b100000;
    applyStimulus(s); checkOutput("fwd_f0_M", 1'b1, 4'b0000, 4'b0000, 6'b001000, 1'b0);

    // Load-use: one bubble, then the load has moved on.
    s = '0; s.eIsLoad = 1'b1; s.eRegWrite = 1'b1; s.eRd = 6'd7; s.dRs = {6'd7, 6'd0, 6'd0}; s.dSrcValid = 3'b100;
    applyStimulus(s); checkOutput("lu_hit", 1'b1, 4'b1100, 4'b0100, 6'b000000, 1'b0);
    s.eIsLoad = 1'b0; s.eRegWrite = 1'b0;
    applyStimulus(s); checkOutput("lu_after", 1'b1, 4'b0000, 4'b0000, 6'b000000, 1'b0);
    s.eIsLoad = 1'b1; s.eRegWrite = 1'b1; s.dSrcValid = 3'b011;
    applyStimulus(s); checkOutput("lu_invalid", 1'b1, 4'b0000, 4'b0000, 6'b000000, 1'b0);
    s.eRd = 6'd0; s.dRs = '0; s.dSrcValid = 3'b111;
    applyStimulus(s); checkOutput("lu_x0", 1'b1, 4'b0000, 4'b0000, 6'b000000, 1'b0);

    // Two back-to-back multi-cycle ops: stall 3, release on the 4th, twice.
    s = '0; s.eMulDiv = 1'b1;
    for (int c = 0; c < 8; c++) begin
      applyStimulus(s);
      checkOutput("mdu_b2b", 1'b1, (c % 4 != 3) ? 4'b1110 : 4'b0000,
                  (c % 4 != 3) ? 4'b0010 : 4'b0000, 6'b000000, (c % 4 != 0));
    end
    s = '0;
    applyStimulus(s); checkOutput("mdu_done", 1'b1, 4'b0000, 4'b0000, 6'b000000, 1'b0);

    // Memory wait for two cycles while cnt==1: occupancy becomes 4+2.
    s = '0; s.eMulDiv = 1'b1;
    applyStimulus(s); checkOutput("ms_c1", 1'b1, 4'b1110, 4'b0010, 6'b000000, 1'b0);
    applyStimulus(s); checkOutput("ms_c2", 1'b1, 4'b1110, 4'b0010, 6'b000000, 1'b1);
    s.memStall = 1'b1;
    applyStimulus(s); checkOutput("ms_c3", 1'b1, 4'b1111, 4'b0001, 6'b000000, 1'b1);
    applyStimulus(s); checkOutput("ms_c4", 1'b1, 4'b1111, 4'b0001, 6'b000000, 1'b1);
    s.memStall = 1'b0;
    applyStimulus(s); checkOutput("ms_c5", 1'b1, 4'b1110, 4'b0010, 6'b000000, 1'b1);
    applyStimulus(s); checkOutput("ms_c6", 1'b1, 4'b0000, 4'b0000, 6'b000000, 1'b1);
    s = '0;
    applyStimulus(s); checkOutput("ms_c7", 1'b1, 4'b0000, 4'b0000, 6'b000000, 1'b0);

    // Branch overrides load-use; branch deferred under a memory wait.
    s = '0; s.eIsLoad = 1'b1; s.eRegWrite = 1'b1; s.eRd = 6'd7; s.dRs = {6'd7, 6'd0, 6'd0};
    s.dSrcValid = 3'b100; s.ePCSrc = 1'b1;
    applyStimulus(s); checkOutput("br_lu", 1'b1, 4'b0000, 4'b1100, 6'b000000, 1'b0);
    s = '0; s.ePCSrc = 1'b1; s.memStall = 1'b1;
    applyStimulus(s); checkOutput("br_ms", 1'b1, 4'b1111, 4'b0001, 6'b000000, 1'b0);
    s.memStall = 1'b0;
    applyStimulus(s); checkOutput("br_go", 1'b1, 4'b0000, 4'b1100, 6'b000000, 1'b0);

    // Reset in BUSY aborts the op; the next op gets the full count.
    s = '0; s.eMulDiv = 1'b1;
    applyStimulus(s); checkOutput("rst_c1", 1'b1, 4'b1110, 4'b0010, 6'b000000, 1'b0);
    applyStimulus(s); checkOutput("rst_c2", 1'b1, 4'b1110, 4'b0010, 6'b000000, 1'b1);
    #2 rst_n = 1'b0;
    #1 checkOutput("rst_async", 1'b0, 4'b0000, 4'b1111, 6'b000000, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    checkOutput("rst_r1", 1'b1, 4'b1110, 4'b0010, 6'b000000, 1'b0);
    applyStimulus(s); checkOutput("rst_r2", 1'b1, 4'b1110, 4'b0010, 6'b000000, 1'b1);
    applyStimulus(s); checkOutput("rst_r3", 1'b1, 4'b1110, 4'b0010, 6'b000000, 1'b1);
    applyStimulus(s); checkOutput("rst_r4", 1'b1, 4'b0000, 4'b0000, 6'b000000, 1'b1);
    s = '0;
    applyStimulus(s); checkOutput("rst_done", 1'b1, 4'b0000, 4'b0000, 6'b000000, 1'b0);

    @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
